// File: rtl/fma_pkg.sv
// fma_pkg: widths, stage payload and shamt-slice helper for fma_align_pipe.
// ALIGN_GRS_EN widens the carried data by two bits so guard/round survive the pipeline.
package fma_pkg;
    localparam int SIG_WIDTH   = 23;
    localparam int SHAMT_WIDTH = 7;
    localparam int TAG_WIDTH   = 4;
    localparam int OUT_W       = 3*(SIG_WIDTH+1)+7;
    localparam int PAD_W       = OUT_W-SIG_WIDTH-2;
`ifdef ALIGN_GRS_EN
    localparam int EXT_W       = 2;
`else
    localparam int EXT_W       = 0;
`endif
    localparam int DATA_W      = OUT_W+EXT_W;
    localparam int PAY_W       = DATA_W+1+SHAMT_WIDTH+TAG_WIDTH;

    typedef struct packed {
        logic [DATA_W-1:0]      data;
        logic                   sticky;
        logic [SHAMT_WIDTH-1:0] shamt;
        logic [TAG_WIDTH-1:0]   tag;
    } payload_t;

    // shamt bits owned by stage k of n, LSB group first
    function automatic logic [SHAMT_WIDTH-1:0] stage_mask(input int k, input int n);
        int lo;
        int hi;
        lo = k*SHAMT_WIDTH/n;
        hi = (k+1)*SHAMT_WIDTH/n;
        return SHAMT_WIDTH'((1 << hi) - (1 << lo));
    endfunction
endpackage

// File: rtl/fma_align_pipe_stage.sv
// align_shift_stage: one registered alignment stage; shifts by its shamt slice and folds
// every bit pushed past bit 0 into the running sticky.
module align_shift_stage
    import fma_pkg::*;
#(
    parameter int K  = 0,
    parameter int NS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [PAY_W-1:0] i_p,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [PAY_W-1:0] o_p
);
    localparam logic [SHAMT_WIDTH-1:0] MASK = stage_mask(K, NS);
    payload_t               w_in;
    payload_t               w_nxt;
    logic [SHAMT_WIDTH-1:0] w_amt;
    logic                   r_v;
    payload_t               r_p;
    always_comb begin
        w_in         = payload_t'(i_p);
        w_amt        = w_in.shamt & MASK;
        w_nxt.data   = w_in.data >> w_amt;
        w_nxt.sticky = w_in.sticky | (|(w_in.data & ~({DATA_W{1'b1}} << w_amt)));
        w_nxt.shamt  = w_in.shamt & ~MASK;
        w_nxt.tag    = w_in.tag;
    end
    assign o_ready = ~r_v | i_ready;
    assign o_valid = r_v;
    assign o_p     = r_p;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= 1'b0;
            r_p <= '0;
        end else if (o_ready) begin
            r_v <= i_valid;
            if (i_valid) r_p <= w_nxt;
        end
    end
endmodule

// File: rtl/fma_align_pipe.sv
// fma_align_pipe: STAGES-deep addend aligner with valid/ready, exact sticky and tag passthrough.
// ALIGN_GRS_EN adds out_guard/out_round and removes those two bits from out_sticky.
module fma_align_pipe
    import fma_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SIG_WIDTH:0]     in_c,
    input  logic [SHAMT_WIDTH-1:0] in_shamt,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_c_al,
    output logic                   out_sticky,
`ifdef ALIGN_GRS_EN
    output logic                   out_guard,
    output logic                   out_round,
`endif
    output logic [TAG_WIDTH-1:0]   out_tag
);
    logic             w_v   [STAGES+1];
    logic             w_rdy [STAGES+1];
    logic [PAY_W-1:0] w_p   [STAGES+1];
    payload_t         w_head;
    payload_t         w_tail;
    logic             w_unused;
    always_comb begin
        w_head.data   = {1'b0, in_c, {(PAD_W+EXT_W){1'b0}}};
        w_head.sticky = 1'b0;
        w_head.shamt  = in_shamt;
        w_head.tag    = in_tag;
    end
    assign w_p[0]        = w_head;
    assign w_v[0]        = in_valid;
    assign in_ready      = w_rdy[0];
    assign w_rdy[STAGES] = out_ready;
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        align_shift_stage #(.K(k), .NS(STAGES)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_v[k]),
            .o_ready (w_rdy[k]),
            .i_p     (w_p[k]),
            .o_valid (w_v[k+1]),
            .i_ready (w_rdy[k+1]),
            .o_p     (w_p[k+1])
        );
    end
    assign w_tail     = payload_t'(w_p[STAGES]);
    assign out_valid  = w_v[STAGES];
    assign out_c_al   = w_tail.data[DATA_W-1:EXT_W];
    assign out_sticky = w_tail.sticky;
    assign out_tag    = w_tail.tag;
`ifdef ALIGN_GRS_EN
    assign out_guard  = w_tail.data[1];
    assign out_round  = w_tail.data[0];
`endif
    // residual shamt is fully consumed by the last stage
    assign w_unused   = ^w_tail.shamt;
endmodule

// File: tb/tb_fma_align_pipe.sv
// tb_fma_align_pipe: directed vectors, streaming/stall and reset checks plus a random sweep
// against a wide-shift golden model.
module tb_fma_align_pipe;
    localparam int NS = 2;
`ifdef ALIGN_GRS_EN
    localparam bit GRS = 1'b1;
`else
    localparam bit GRS = 1'b0;
`endif
    typedef struct {
        logic [78:0] c;
        logic        s;
        logic        g;
        logic        r;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_c = '0;
    logic [6:0]  in_shamt = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [78:0] out_c_al;
    logic        out_sticky;
    logic [3:0]  out_tag;
`ifdef ALIGN_GRS_EN
    logic        out_guard;
    logic        out_round;
`endif
    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          rdy_mode = 0;
    int          pat = 0;
    exp_t        q[$];
    exp_t        e_m;
    logic        last_stall = 1'b0;
    logic [78:0] last_c;
    logic [3:0]  last_tag;

    always #5 clk = ~clk;

    fma_align_pipe #(.STAGES(NS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_c       (in_c),
        .in_shamt   (in_shamt),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_c_al   (out_c_al),
        .out_sticky (out_sticky),
`ifdef ALIGN_GRS_EN
        .out_guard  (out_guard),
        .out_round  (out_round),
`endif
        .out_tag    (out_tag)
    );

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [23:0] c, input logic [6:0] sh, input logic [3:0] tag);
        logic [206:0] f;
        exp_t e;
        f = {1'b0, c, 54'b0, 128'b0} >> sh;
        e.c = f[206:128];
        e.tag = tag;
        e.g = GRS ? f[127] : 1'b0;
        e.r = GRS ? f[126] : 1'b0;
        e.s = GRS ? |f[125:0] : |f[127:0];
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = rdy_mode == 0 ? 1'b1 :
                    rdy_mode == 1 ? (pat % 3 == 0) :
                    rdy_mode == 2 ? ($urandom_range(0, 3) != 0) : 1'b0;
        pat++;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            last_stall = 1'b0;
        end else begin
            if (last_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_c", out_c_al, last_c);
                chk("stall_tag", out_tag, last_tag);
            end
            chk("in_ready", in_ready, !(q.size() == NS && !out_ready));
            if (in_valid && in_ready) q.push_back(model(in_c, in_shamt, in_tag));
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", out_valid, 0);
                else begin
                    e_m = q.pop_front();
                    chk("sb_c", out_c_al, e_m.c);
                    chk("sb_sticky", out_sticky, e_m.s);
                    chk("sb_tag", out_tag, e_m.tag);
`ifdef ALIGN_GRS_EN
                    chk("sb_guard", out_guard, e_m.g);
                    chk("sb_round", out_round, e_m.r);
`endif
                    n_out++;
                end
            end
            last_stall = out_valid && !out_ready;
            last_c = out_c_al;
            last_tag = out_tag;
        end
    end

    task automatic do_vec(input logic [23:0] c, input logic [6:0] sh, input logic [3:0] tag,
                          input logic [78:0] ec, input logic es);
        in_valid = 1'b1;
        in_c = c;
        in_shamt = sh;
        in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat1_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("lat2_valid", out_valid, 1);
        chk("dir_c", out_c_al, ec);
        chk("dir_sticky", out_sticky, es);
        chk("dir_tag", out_tag, tag);
    endtask

    task automatic push_op(input logic [23:0] c, input logic [6:0] sh, input logic [3:0] tag);
        int n = 0;
        in_valid = 1'b1;
        in_c = c;
        in_shamt = sh;
        in_tag = tag;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_c", out_c_al, 0);
        chk("rst_sticky", out_sticky, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        do_vec(24'h800000, 7'd0, 4'd1, 79'h2000_0000_0000_0000_0000, 1'b0);
        do_vec(24'h800001, 7'd77, 4'd2, 79'h1, 1'b1);
`ifdef ALIGN_GRS_EN
        chk("grs_guard", out_guard, 0);
        chk("grs_round", out_round, 0);
`endif
        do_vec(24'h000001, 7'd100, 4'd3, 79'h0, 1'b1);
        do_vec(24'h000000, 7'd127, 4'd4, 79'h0, 1'b0);
        do_vec(24'hFFFFFF, 7'd54, 4'd5, 79'hFFFFFF, 1'b0);
        do_vec(24'hFFFFFF, 7'd55, 4'd6, 79'h7FFFFF, !GRS);
        do_vec(24'hFFFFFF, 7'd79, 4'd7, 79'h0, 1'b1);
        do_vec(24'h000000, 7'd0, 4'd8, 79'h0, 1'b0);
        @(posedge clk); #1;

        rdy_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        push_op(24'hABCDEF, 7'd3, 4'hA);
        push_op(24'h123456, 7'd9, 4'hB);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_c", out_c_al, 0);
        chk("mid_rst_sticky", out_sticky, 0);
        chk("mid_rst_tag", out_tag, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        rdy_mode = 0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("post_rst_valid", out_valid, 0);
        end

        rdy_mode = 1;
        n_out = 0;
        for (int i = 0; i < 8; i++)
            push_op(24'h800000 | 24'(i * 24'h01F3A5), 7'(i * 11), 4'(i));
        drain();
        chk("stream_count", n_out, 8);

        rdy_mode = 2;
        for (int i = 0; i < 10000; i++)
            push_op(($urandom_range(0, 15) == 0) ? 24'h0 : 24'($urandom), 7'($urandom), 4'(i));
        drain();
        rdy_mode = 0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
